alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Parameters
REQ-001 SHALL provide WIDTH, default 32, operand and result width in bits; legal values 8, 16, 32 or 64.
REQ-002 SHALL provide SHW, default $clog2(WIDTH), number of low bits of B used as the shift amount.

Interface
REQ-003 SHALL have clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have in_valid, input, 1 bit: an operation request is present.
REQ-006 SHALL have in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have A, input, WIDTH bits: first operand.
REQ-008 SHALL have B, input, WIDTH bits: second operand.
REQ-009 SHALL have ALUOp, input, 4 bits, with this encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR
- 4 SRL, 5 SRA, 6 SLL, 7 SLT (signed), 8 SLTU
- 9 MULU, 10 DIVU
- 11-15 illegal
REQ-010 SHALL have out_valid, output, 1 bit: a result is present.
REQ-011 SHALL have out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have C, output, WIDTH bits: primary result (MULU low half, DIVU quotient).
REQ-013 SHALL have H, output, WIDTH bits: MULU high half, DIVU remainder, 0 for all other ops.
REQ-014 SHALL have err, output, 1 bit: an illegal op or divide-by-zero occurred; valid while out_valid is high.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, BUSY, DONE.
REQ-016 SHALL drive in_ready high only in IDLE; a request is accepted on a rising edge where in_valid and in_ready are both high.
REQ-017 SHALL register A, B and ALUOp on acceptance; later input changes SHALL NOT affect the operation in flight.
REQ-018 SHALL handle ops 0-8 and illegal ops in one cycle:
- the result is registered at the accepting edge and the FSM goes IDLE to DONE;
- out_valid is high from that edge onward (latency 1).
REQ-019 SHALL compute ADD, SUB, AND, OR modulo 2^WIDTH, with no carry or overflow output.
REQ-020 SHALL use only B[SHW-1:0] as the shift amount for SRL, SRA and SLL; SRA fills with A[WIDTH-1].
REQ-021 SHALL return 1 or 0 in C for SLT (signed compare) and SLTU (unsigned compare).
REQ-022 SHALL handle MULU and DIVU as follows:
- on acceptance the FSM goes IDLE to BUSY and loads a counter with WIDTH;
- one shift-add (MULU) or restoring-subtract (DIVU) step per cycle; the counter decrements each cycle;
- the FSM goes BUSY to DONE on the edge where the counter reaches 0;
- out_valid rises WIDTH cycles after acceptance.
REQ-023 SHALL produce for MULU the unsigned 2*WIDTH-bit product {H,C}.
REQ-024 SHALL produce for DIVU C = unsigned quotient and H = remainder.
REQ-025 SHALL handle DIVU with B=0 as follows:
- C = all ones, H = A, err = 1;
- latency is still WIDTH cycles.
REQ-026 SHALL handle an illegal ALUOp as follows: C = 0, H = 0, err = 1, latency 1.
REQ-027 SHALL hold C, H and err stable in DONE until the result is taken.
REQ-028 SHALL go DONE to IDLE on the edge where out_ready is high; out_ready is ignored outside DONE.
REQ-029 SHALL NOT accept back-to-back requests: the earliest next acceptance is the cycle after the result is taken.
REQ-030 SHALL ignore in_valid in BUSY and DONE; no request is queued.
REQ-031 SHALL never assert in_ready and out_valid in the same cycle.

Reset
REQ-032 SHALL, while reset is high, immediately force:
- state IDLE, counter 0;
- C = 0, H = 0, err = 0, out_valid = 0;
- in_ready = 0.
REQ-033 SHALL raise in_ready on the first rising edge after reset deasserts.
REQ-034 SHALL, if reset asserts during BUSY or DONE, abort the operation with no result emitted; the next request SHALL complete normally.

Verification (WIDTH=32)
REQ-035 Bench SHALL check: ADD 0xFFFFFFFF + 1 -> C=0, H=0, err=0; out_valid rises 1 cycle after acceptance.
REQ-036 Bench SHALL check: SRA A=0x80000000, B=0x24 (shift 4) -> C=0xF8000000; SLT A=0xFFFFFFFF, B=1 -> C=1; SLTU with the same operands -> C=0.
REQ-037 Bench SHALL check: MULU 0xFFFFFFFF * 2 -> C=0xFFFFFFFE, H=0x00000001; out_valid rises exactly 32 cycles after acceptance; in_ready is low throughout.
REQ-038 Bench SHALL check: DIVU 100 / 7 -> C=14, H=2; DIVU 5 / 0 -> C=0xFFFFFFFF, H=5, err=1.
REQ-039 Bench SHALL check backpressure: out_ready held low for 10 cycles in DONE -> C, H and out_valid stay stable and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge, then in_ready=1.
REQ-040 Bench SHALL check: reset pulsed at cycle 10 of a MULU -> outputs zero immediately, no out_valid; a following ADD 3+4 -> C=7.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on each side.
// Ops 0-8 finish in one cycle; MULU and DIVU run one shift step per cycle for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] H,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SRL  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] h_r;
  logic             err_r;

  // Iterative datapath: hi holds partial product / remainder, lo holds
  // multiplier / dividend-turned-quotient, opa holds multiplicand / divisor.
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opa_r;
  logic             is_div_r;
  logic             div0_r;

  logic             accept_s;
  logic             is_multi_s;
  logic             last_step_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_c_s;
  logic             alu_err_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;
  logic [WIDTH:0]   rem_sh_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] rem_sub_s;
  logic [WIDTH-1:0] div_hi_s;
  logic [WIDTH-1:0] div_lo_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign C         = c_r;
  assign H         = h_r;
  assign err       = err_r;

  // Handshake qualifiers
  always_comb begin
    accept_s    = in_valid && in_ready_r && (state_r == S_IDLE);
    is_multi_s  = (ALUOp == OP_MULU) || (ALUOp == OP_DIVU);
    last_step_s = (state_r == S_BUSY) && (cnt_r == CW'(1));
  end

  // Single-cycle operations, evaluated on the live inputs at the accepting edge
  always_comb begin
    alu_c_s   = '0;
    alu_err_s = 1'b0;
    shamt_s   = B[SHW-1:0];
    case (ALUOp)
      OP_ADD:  alu_c_s = A + B;
      OP_SUB:  alu_c_s = A - B;
      OP_AND:  alu_c_s = A & B;
      OP_OR:   alu_c_s = A | B;
      OP_SRL:  alu_c_s = A >> shamt_s;
      OP_SRA:  alu_c_s = $unsigned($signed(A) >>> shamt_s);
      OP_SLL:  alu_c_s = A << shamt_s;
      OP_SLT:  alu_c_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_c_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_MULU: alu_c_s = '0;
      OP_DIVU: alu_c_s = '0;
      default: alu_err_s = 1'b1;
    endcase
  end

  // One shift-add (multiply) or restoring-subtract (divide) step
  always_comb begin
    add_s     = lo_r[0] ? ({1'b0, hi_r} + {1'b0, opa_r}) : {1'b0, hi_r};
    mul_hi_s  = add_s[WIDTH:1];
    mul_lo_s  = {add_s[0], lo_r[WIDTH-1:1]};
    rem_sh_s  = {hi_r, lo_r[WIDTH-1]};
    div_ge_s  = (rem_sh_s >= {1'b0, opa_r});
    rem_sub_s = rem_sh_s[WIDTH-1:0] - opa_r;
    div_hi_s  = div_ge_s ? rem_sub_s : rem_sh_s[WIDTH-1:0];
    div_lo_s  = {lo_r[WIDTH-2:0], div_ge_s};
    step_hi_s = is_div_r ? div_hi_s : mul_hi_s;
    step_lo_s = is_div_r ? div_lo_s : mul_lo_s;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = is_multi_s ? S_BUSY : S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        if (last_step_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they follow it edge for edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_s == S_DONE);
    end
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      opa_r    <= '0;
      is_div_r <= 1'b0;
      div0_r   <= 1'b0;
      c_r      <= '0;
      h_r      <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s && is_multi_s) begin
            is_div_r <= (ALUOp == OP_DIVU);
            div0_r   <= (ALUOp == OP_DIVU) && (B == '0);
            hi_r     <= '0;
            lo_r     <= (ALUOp == OP_DIVU) ? A : B;
            opa_r    <= (ALUOp == OP_DIVU) ? B : A;
            cnt_r    <= CW'(WIDTH);
          end else if (accept_s) begin
            c_r   <= alu_c_s;
            h_r   <= '0;
            err_r <= alu_err_s;
          end
        end
        S_BUSY: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r - CW'(1);
          if (last_step_s) begin
            c_r   <= step_lo_s;
            h_r   <= step_hi_s;
            err_r <= div0_r;
          end
        end
        S_DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): a stimulus thread pushes expected results into a
// queue and a negedge monitor pops and compares them whenever a result is handed over.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] C;
  logic [31:0] H;
  logic        err;

  typedef struct {
    logic [31:0] c;
    logic [31:0] h;
    logic        e;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic overlap_seen = 1'b0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .H         (H),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every result at the moment it is handed over
  always @(negedge clk) begin
    if (!reset) begin
      if (in_ready && out_valid) overlap_seen = 1'b1;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", {32'h0, C}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check({e.name, "_C"}, {32'h0, C}, {32'h0, e.c});
          check({e.name, "_H"}, {32'h0, H}, {32'h0, e.h});
          check({e.name, "_err"}, {63'h0, err}, {63'h0, e.e});
        end
      end
    end
  end

  task automatic push(input string name, input logic [31:0] c, input logic [31:0] h, input logic e);
    exp_t x;
    x.c = c; x.h = h; x.e = e; x.name = name;
    sb_q.push_back(x);
  endtask

  // Wait for in_ready, present one request, then scramble the inputs after acceptance
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", {63'h0, in_ready}, 64'h1);
    in_valid = 1'b1; ALUOp = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; ALUOp = 4'd15; A = ~a; B = ~b;
  endtask

  // Count edges from the accepting edge until out_valid; in_ready must stay low meanwhile
  task automatic wait_valid(input string name, input int exp_edges);
    int   n = 0;
    logic rdy = 1'b0;
    while (!out_valid && n < 100) begin
      rdy |= in_ready;
      @(posedge clk); #1; n++;
    end
    rdy |= in_ready;
    check({name, "_latency"}, 64'(n), 64'(exp_edges));
    check({name, "_in_ready_low"}, {63'h0, rdy}, 64'h0);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c, input logic [31:0] h,
                     input logic e, input int lat);
    push(name, c, h, e);
    send(op, a, b);
    wait_valid(name, lat);
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c0, h0;
    logic        stable;
    logic        early;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 32'h0; B = 32'h0; ALUOp = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_C", {32'h0, C}, 64'h0);
    check("rst_H", {32'h0, H}, 64'h0);
    check("rst_flags", {61'h0, err, out_valid, in_ready}, 64'h0);
    reset = 1'b0;
    #1;
    check("in_ready_before_edge", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    check("in_ready_after_edge", {63'h0, in_ready}, 64'h1);

    run("add_wrap", 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 0);
    run("sub",      4'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1'b0, 0);
    run("and",      4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 0);
    run("or",       4'd3,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 0);
    run("srl",      4'd4,  32'h80000000, 32'h00000021, 32'h40000000, 32'h0, 1'b0, 0);
    run("sra",      4'd5,  32'h80000000, 32'h00000024, 32'hF8000000, 32'h0, 1'b0, 0);
    run("sll",      4'd6,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 1'b0, 0);
    run("slt",      4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 0);
    run("sltu",     4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 0);
    run("illegal11",4'd11, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0, 1'b1, 0);
    run("illegal15",4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 0);
    run("mulu_x2",  4'd9,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0, 32);
    run("mulu_max", 4'd9,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32);
    run("divu",     4'd10, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 32);
    run("divu_lt",  4'd10, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 32);
    run("divu_0",   4'd10, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 32);

    // Backpressure: result must hold for 10 cycles while new requests are ignored
    push("bp_add", 32'h00000030, 32'h0, 1'b0);
    send(4'd0, 32'h00000010, 32'h00000020);
    wait_valid("bp_add", 0);
    c0 = C; h0 = H; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; ALUOp = 4'd1; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      if (C !== c0 || H !== h0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    check("bp_stable", {63'h0, stable}, 64'h1);
    take();
    check("bp_in_ready_after_take", {63'h0, in_ready}, 64'h1);
    check("bp_out_valid_after_take", {63'h0, out_valid}, 64'h0);

    // Reset in the middle of a multiply aborts it without a result
    send(4'd9, 32'hFFFFFFFF, 32'h00000002);
    early = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      early |= out_valid;
    end
    check("abort_no_early_valid", {63'h0, early}, 64'h0);
    #2 reset = 1'b1;
    #1;
    check("abort_C", {32'h0, C}, 64'h0);
    check("abort_H", {32'h0, H}, 64'h0);
    check("abort_flags", {61'h0, err, out_valid, in_ready}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", {63'h0, in_ready}, 64'h1);
    check("abort_out_valid", {63'h0, out_valid}, 64'h0);
    run("post_reset_add", 4'd0, 32'd3, 32'd4, 32'd7, 32'h0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    check("no_ready_valid_overlap", {63'h0, overlap_seen}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
